ultrasonido_medicion: RTL and testbench
=======================================

// Module: ultrasonido_medicion
// PURPOSE
//  Measurement engine driven by the ultrasonic control block's ENABLE/reset outputs. While ENABLE is
//  high it fires an HC-SR04 trigger pulse, times the echo pulse and reports distance in cm with a done
//  strobe, then repeats after a hold-off. Sits between the control block and the sensor pins.
// PARAMETERS
//  CLK_FREQ_HZ  25_000_000  CLKOUT2 frequency; derives the 1 us tick (CLKS_PER_US = CLK_FREQ_HZ/1e6)
//  TRIG_US      10          trigger pulse width, us
//  US_PER_CM    58          echo us per cm of distance
//  TIMEOUT_US   30000       max wait for echo rise, and max echo width, us
//  HOLDOFF_US   60000       idle gap between consecutive measurements, us
//  DIST_W       9           distance width; saturates at 2**DIST_W-2
// PORTS
//  CLKOUT2   in   1       system clock; all logic on its rising edge
//  reset     in   1       synchronous, active-high reset
//  ENABLE    in   1       level; high = measure continuously, low = abort/idle
//  echo      in   1       sensor echo pin, asynchronous; 2-flop synchronised internally
//  trigger   out  1       sensor trigger pin
//  distance  out  DIST_W  last result in cm; all-ones = timeout
//  done      out  1       1-cycle strobe, distance/timeout updated on this cycle
//  timeout   out  1       sticky per result: 1 when last measurement timed out
//  busy      out  1       high in any state except IDLE
// BEHAVIOUR
//  Reset: trigger=0, distance=0, done=0, timeout=0, busy=0, state=IDLE, all counters 0, sync flops 0.
//  Tick: 1-cycle us_tick every CLKS_PER_US cycles; prescaler cleared on state entry so phases are exact.
//  States/transitions:
//   IDLE      ENABLE=1 -> TRIG.
//   TRIG      trigger=1 for exactly TRIG_US*CLKS_PER_US cycles, then trigger=0 -> WAIT_ECHO.
//   WAIT_ECHO synced echo rise -> MEASURE (us and cm counters cleared);
//             TIMEOUT_US elapsed -> result timeout -> HOLDOFF.
//   MEASURE   cm counter +1 every US_PER_CM ticks, saturating at 2**DIST_W-2;
//             synced echo fall -> result ok -> HOLDOFF; echo width > TIMEOUT_US -> result timeout -> HOLDOFF.
//   HOLDOFF   HOLDOFF_US elapsed -> TRIG if ENABLE=1 else IDLE.
//  Result ok: distance<=cm count (floor of width/US_PER_CM), timeout<=0, done=1 same cycle.
//  Result timeout: distance<=all ones, timeout<=1, done=1.
//  Latency: done asserts 3 cycles after raw echo falls (2 sync + 1 register).
//  ENABLE low in any state: next cycle -> IDLE, trigger=0, no done, distance/timeout keep last value.
//  ENABLE low and echo edge same cycle: abort wins.
//  echo high on entry to WAIT_ECHO (stale pulse): not a rise; wait for low-then-high.
//  reset overrides everything, including mid-trigger (trigger drops next edge).
//  Counter widths from $clog2 of the max count of each; no wrap-around anywhere.
// STRUCTURE
//  Package ultrasonido_pkg: state enum (IDLE,TRIG,WAIT_ECHO,MEASURE,HOLDOFF) and its encoding,
//   DIST_TIMEOUT (all-ones) constant, and the us conversion helper function.
//  Sub-module us_tick_gen (CLKOUT2, reset, clr, us_tick): prescaler; FSM, counters and result registers stay top-level.
// TESTING  (CLK_FREQ_HZ=25e6 unless noted; sim may shrink HOLDOFF_US to 100)
//  1 ENABLE=1 from IDLE -> trigger high exactly 250 cycles, busy=1.
//  2 echo high 580 us -> done once, distance=10, timeout=0; 1159 us -> distance=19.
//  3 echo never rises -> done after 30000 us in WAIT_ECHO, distance=511, timeout=1.
//  4 echo held high 31000 us -> done at 30000 us of echo, distance=511, timeout=1.
//  5 ENABLE low mid-MEASURE -> IDLE next cycle, no done, distance unchanged, busy=0.
//  6 reset high during TRIG -> trigger=0, all outputs at reset values; ENABLE still 1 -> new 250-cycle trigger after reset drops.

Source files
------------

// File: rtl/ultrasonido_pkg.sv
// Shared types and helpers for the ultrasonic measurement engine.
package ultrasonido_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  // Sliced down to the distance width; all-ones marks a timed-out result.
  localparam logic [31:0] DIST_TIMEOUT = '1;

  function automatic int us_to_clks(input int clk_freq_hz, input int us);
    return (clk_freq_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/ultrasonido_medicion_if.sv
// Sensor-side and control-side signals of the measurement engine.
interface ultrasonido_medicion_if #(parameter int DIST_W = 9);
  logic              ENABLE;
  logic              echo;
  logic              trigger;
  logic [DIST_W-1:0] distance;
  logic              done;
  logic              timeout;
  logic              busy;

  modport master (output ENABLE, echo, input trigger, distance, done, timeout, busy);
  modport slave  (input ENABLE, echo, output trigger, distance, done, timeout, busy);
endinterface

// File: rtl/ultrasonido_medicion_us_tick_gen.sv
// Microsecond prescaler; clr marks the first cycle of a new phase so the
// k-th tick lands on the last cycle of the k-th microsecond of that phase.
module us_tick_gen #(
  parameter int CLKS_PER_US = 25
) (
  input  logic CLKOUT2,
  input  logic reset,
  input  logic clr,
  output logic us_tick
);
  localparam int CNT_W = $clog2(CLKS_PER_US + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLKOUT2) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= (CLKS_PER_US > 1) ? CNT_W'(CLKS_PER_US - 2) : '0;
    else if (cnt == '0)
      cnt <= CNT_W'(CLKS_PER_US - 1);
    else
      cnt <= cnt - 1'b1;
  end

  assign us_tick = clr ? (CLKS_PER_US == 1) : (cnt == '0);
endmodule

// File: rtl/ultrasonido_medicion.sv
// HC-SR04 measurement engine: trigger, echo timing, distance in cm, hold-off.
//  state     | meaning
//  IDLE      | ENABLE low, nothing in flight
//  TRIG      | trigger pin high for TRIG_US
//  WAIT_ECHO | waiting for a fresh echo rise, bounded by TIMEOUT_US
//  MEASURE   | echo high, counting cm, bounded by TIMEOUT_US
//  HOLDOFF   | gap of HOLDOFF_US before the next trigger
module ultrasonido_medicion
  import ultrasonido_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int TRIG_US     = 10,
  parameter int US_PER_CM   = 58,
  parameter int TIMEOUT_US  = 30000,
  parameter int HOLDOFF_US  = 60000,
  parameter int DIST_W      = 9
) (
  input  logic CLKOUT2,
  input  logic reset,
  ultrasonido_medicion_if.slave bus
);
  localparam int CLKS_PER_US = us_to_clks(CLK_FREQ_HZ, 1);
  localparam int US_MAX0     = (TIMEOUT_US > HOLDOFF_US) ? TIMEOUT_US : HOLDOFF_US;
  localparam int US_MAX      = (US_MAX0 > TRIG_US) ? US_MAX0 : TRIG_US;
  localparam int US_W        = $clog2(US_MAX + 1);
  localparam int DIV_W       = $clog2(US_PER_CM + 1);
  localparam int CM_MAX      = (1 << DIST_W) - 2;

  state_t            state;
  logic              phase_clr, us_tick, us_last, cm_step;
  logic              e_s1, e_s2, armed;
  logic [US_W-1:0]   us_left;
  logic [DIV_W-1:0]  cm_div;
  logic [DIST_W-1:0] cm, cm_inc;
  logic              trigger_r, done_r, timeout_r, busy_r;
  logic [DIST_W-1:0] distance_r;

  us_tick_gen #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
    .CLKOUT2 (CLKOUT2),
    .reset   (reset),
    .clr     (phase_clr),
    .us_tick (us_tick)
  );

  always_ff @(posedge CLKOUT2) begin
    if (reset) begin
      e_s1 <= 1'b0;
      e_s2 <= 1'b0;
    end else begin
      e_s1 <= bus.echo;
      e_s2 <= e_s1;
    end
  end

  assign us_last = us_tick && (us_left == US_W'(1));
  assign cm_step = us_tick && (cm_div == DIV_W'(1));
  // Includes a cm step landing on the same cycle as the echo fall.
  assign cm_inc  = (cm_step && (cm != DIST_W'(CM_MAX))) ? cm + 1'b1 : cm;

  always_ff @(posedge CLKOUT2) begin
    if (reset) begin
      state      <= IDLE;
      trigger_r  <= 1'b0;
      distance_r <= '0;
      done_r     <= 1'b0;
      timeout_r  <= 1'b0;
      busy_r     <= 1'b0;
      phase_clr  <= 1'b0;
      armed      <= 1'b0;
      us_left    <= '0;
      cm_div     <= '0;
      cm         <= '0;
    end else begin
      done_r    <= 1'b0;
      phase_clr <= 1'b0;
      if (us_tick && (us_left != '0))
        us_left <= us_left - 1'b1;
      if (!bus.ENABLE) begin
        state     <= IDLE;
        trigger_r <= 1'b0;
        busy_r    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state     <= TRIG;
            trigger_r <= 1'b1;
            busy_r    <= 1'b1;
            phase_clr <= 1'b1;
            us_left   <= US_W'(TRIG_US);
          end
          TRIG: if (us_last) begin
            state     <= WAIT_ECHO;
            trigger_r <= 1'b0;
            phase_clr <= 1'b1;
            armed     <= 1'b0;
            us_left   <= US_W'(TIMEOUT_US);
          end
          WAIT_ECHO: begin
            // A pulse already high on entry only counts after it is seen low.
            if (armed && e_s2) begin
              state     <= MEASURE;
              phase_clr <= 1'b1;
              us_left   <= US_W'(TIMEOUT_US);
              cm_div    <= DIV_W'(US_PER_CM);
              cm        <= '0;
            end else if (us_last) begin
              distance_r <= DIST_TIMEOUT[DIST_W-1:0];
              timeout_r  <= 1'b1;
              done_r     <= 1'b1;
              state      <= HOLDOFF;
              phase_clr  <= 1'b1;
              us_left    <= US_W'(HOLDOFF_US);
            end else if (!e_s2) begin
              armed <= 1'b1;
            end
          end
          MEASURE: begin
            if (!e_s2) begin
              distance_r <= cm_inc;
              timeout_r  <= 1'b0;
              done_r     <= 1'b1;
              state      <= HOLDOFF;
              phase_clr  <= 1'b1;
              us_left    <= US_W'(HOLDOFF_US);
            end else if (us_last) begin
              distance_r <= DIST_TIMEOUT[DIST_W-1:0];
              timeout_r  <= 1'b1;
              done_r     <= 1'b1;
              state      <= HOLDOFF;
              phase_clr  <= 1'b1;
              us_left    <= US_W'(HOLDOFF_US);
            end else if (us_tick) begin
              if (cm_div == DIV_W'(1)) begin
                cm_div <= DIV_W'(US_PER_CM);
                cm     <= cm_inc;
              end else begin
                cm_div <= cm_div - 1'b1;
              end
            end
          end
          HOLDOFF: if (us_last) begin
            state     <= TRIG;
            trigger_r <= 1'b1;
            phase_clr <= 1'b1;
            us_left   <= US_W'(TRIG_US);
          end
          default: begin
            state     <= IDLE;
            trigger_r <= 1'b0;
            busy_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.trigger  = trigger_r;
  assign bus.distance = distance_r;
  assign bus.done     = done_r;
  assign bus.timeout  = timeout_r;
  assign bus.busy     = busy_r;
endmodule

// File: tb/tb_ultrasonido_medicion.sv
// Bench for ultrasonido_medicion: cycle-count reference model plus directed scenarios.
module tb_ultrasonido_medicion;
  localparam int CLK_FREQ_HZ = 10_000_000;
  localparam int TRIG_US     = 10;
  localparam int US_PER_CM   = 58;
  localparam int TIMEOUT_US  = 1200;
  localparam int HOLDOFF_US  = 100;
  localparam int DIST_W      = 9;
  localparam int CPU         = CLK_FREQ_HZ / 1_000_000;
  localparam int TRIG_CYC    = TRIG_US * CPU;
  localparam int TO_CYC      = TIMEOUT_US * CPU;
  localparam int HOLD_CYC    = HOLDOFF_US * CPU;
  localparam int CM_MAX      = (1 << DIST_W) - 2;
  localparam int DIST_ALL1   = (1 << DIST_W) - 1;

  logic CLKOUT2 = 1'b0;
  logic reset   = 1'b1;

  ultrasonido_medicion_if #(.DIST_W(DIST_W)) bus ();

  ultrasonido_medicion #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .TRIG_US     (TRIG_US),
    .US_PER_CM   (US_PER_CM),
    .TIMEOUT_US  (TIMEOUT_US),
    .HOLDOFF_US  (HOLDOFF_US),
    .DIST_W      (DIST_W)
  ) dut (
    .CLKOUT2 (CLKOUT2),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 CLKOUT2 = ~CLKOUT2;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
      if (failures >= 200) begin
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  endtask

  // Reference model in raw clock cycles: phase lengths, echo width -> cm.
  int  m_ph, m_n;
  bit  m_low, m_e1, m_e2, m_valid;
  int  x_trig, x_busy, x_done, x_dist, x_to;

  always @(posedge CLKOUT2) begin
    bit es;
    int cm;
    if (reset) begin
      m_ph = 0; m_n = 0; m_low = 0; m_e1 = 0; m_e2 = 0;
      x_trig = 0; x_busy = 0; x_done = 0; x_dist = 0; x_to = 0;
      m_valid = 1;
    end else begin
      es = m_e2; m_e2 = m_e1; m_e1 = bus.echo;
      x_done = 0;
      if (!bus.ENABLE) m_ph = 0;
      else case (m_ph)
        0: begin m_ph = 1; m_n = 0; end
        1: begin
          m_n++;
          if (m_n == TRIG_CYC) begin m_ph = 2; m_n = 0; m_low = 0; end
        end
        2: begin
          m_n++;
          if (m_low && es) begin m_ph = 3; m_n = 0; end
          else if (m_n == TO_CYC) begin
            x_dist = DIST_ALL1; x_to = 1; x_done = 1; m_ph = 4; m_n = 0;
          end else if (!es) m_low = 1;
        end
        3: begin
          m_n++;
          if (!es) begin
            cm = (m_n / CPU) / US_PER_CM;
            x_dist = (cm > CM_MAX) ? CM_MAX : cm;
            x_to = 0; x_done = 1; m_ph = 4; m_n = 0;
          end else if (m_n == TO_CYC) begin
            x_dist = DIST_ALL1; x_to = 1; x_done = 1; m_ph = 4; m_n = 0;
          end
        end
        default: begin
          m_n++;
          if (m_n == HOLD_CYC) begin m_ph = 1; m_n = 0; end
        end
      endcase
      x_trig = (m_ph == 1);
      x_busy = (m_ph != 0);
    end
  end

  always @(negedge CLKOUT2) begin
    if (m_valid) begin
      check("model_trigger",  int'(bus.trigger),  x_trig);
      check("model_busy",     int'(bus.busy),     x_busy);
      check("model_done",     int'(bus.done),     x_done);
      check("model_timeout",  int'(bus.timeout),  x_to);
      check("model_distance", int'(bus.distance), x_dist);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLKOUT2);
    #1;
  endtask

  function automatic logic sig(input int sel);
    return (sel == 1) ? bus.done : bus.trigger;
  endfunction

  task automatic wait_sig(input string name, input int sel, input logic lvl,
                          input int limit, output int n);
    n = 0;
    while (sig(sel) !== lvl && n < limit) begin
      cyc(1);
      n++;
    end
    check({name, "_seen"}, int'(sig(sel) === lvl), 1);
  endtask

  // Next trigger pulse, returning once it has fallen (start of echo wait).
  task automatic next_trigger(input string name, input int rise_limit);
    int n;
    wait_sig({name, "_rise"}, 0, 1'b1, rise_limit, n);
    wait_sig({name, "_fall"}, 0, 1'b0, TRIG_CYC + 20, n);
  endtask

  initial begin
    int n;
    bus.ENABLE = 1'b0;
    bus.echo   = 1'b0;
    reset      = 1'b1;
    cyc(3);
    check("rst_trigger",  int'(bus.trigger),  0);
    check("rst_distance", int'(bus.distance), 0);
    check("rst_done",     int'(bus.done),     0);
    check("rst_timeout",  int'(bus.timeout),  0);
    check("rst_busy",     int'(bus.busy),     0);
    reset = 1'b0;
    cyc(2);
    check("idle_busy", int'(bus.busy), 0);

    // 1: trigger width and busy
    bus.ENABLE = 1'b1;
    wait_sig("t1_rise", 0, 1'b1, 10, n);
    check("t1_rise_latency", n, 1);
    check("t1_busy", int'(bus.busy), 1);
    wait_sig("t1_fall", 0, 1'b0, 400, n);
    check("t1_trig_width", n, 100);

    // 2a: 580 us echo -> 10 cm, done 3 cycles after raw fall
    cyc(20);
    bus.echo = 1'b1;
    cyc(5800);
    bus.echo = 1'b0;
    wait_sig("t2a_done", 1, 1'b1, 20, n);
    check("t2a_done_latency", n, 3);
    check("t2a_distance", int'(bus.distance), 10);
    check("t2a_timeout",  int'(bus.timeout),  0);
    wait_sig("t2_holdoff", 0, 1'b1, HOLD_CYC + 20, n);
    check("t2_holdoff_cycles", n, 1000);

    // 2b: 1159 us echo -> 19 cm
    wait_sig("t2b_fall", 0, 1'b0, TRIG_CYC + 20, n);
    cyc(20);
    bus.echo = 1'b1;
    cyc(11590);
    bus.echo = 1'b0;
    wait_sig("t2b_done", 1, 1'b1, 20, n);
    check("t2b_distance", int'(bus.distance), 19);
    check("t2b_timeout",  int'(bus.timeout),  0);

    // 3: no echo at all
    next_trigger("t3", HOLD_CYC + 20);
    wait_sig("t3_done", 1, 1'b1, TO_CYC + 50, n);
    check("t3_wait_cycles", n, 12000);
    check("t3_distance", int'(bus.distance), 511);
    check("t3_timeout",  int'(bus.timeout),  1);

    // 4: echo stuck high past the limit
    next_trigger("t4", HOLD_CYC + 20);
    cyc(20);
    bus.echo = 1'b1;
    wait_sig("t4_done", 1, 1'b1, TO_CYC + 50, n);
    check("t4_echo_cycles", n, 12003);
    check("t4_distance", int'(bus.distance), 511);
    check("t4_timeout",  int'(bus.timeout),  1);
    cyc(400);
    bus.echo = 1'b0;

    // 5a: ENABLE drops mid-measurement
    next_trigger("t5a", HOLD_CYC + 20);
    cyc(20);
    bus.echo = 1'b1;
    cyc(1000);
    bus.ENABLE = 1'b0;
    cyc(1);
    check("t5a_busy",     int'(bus.busy),     0);
    check("t5a_trigger",  int'(bus.trigger),  0);
    check("t5a_done",     int'(bus.done),     0);
    check("t5a_distance", int'(bus.distance), 511);
    check("t5a_timeout",  int'(bus.timeout),  1);
    bus.echo = 1'b0;
    cyc(5);

    // 5b: abort on the same cycle the synchronised echo falls
    bus.ENABLE = 1'b1;
    next_trigger("t5b", 10);
    cyc(20);
    bus.echo = 1'b1;
    cyc(600);
    bus.echo = 1'b0;
    cyc(2);
    bus.ENABLE = 1'b0;
    cyc(1);
    check("t5b_done",     int'(bus.done),     0);
    check("t5b_busy",     int'(bus.busy),     0);
    check("t5b_distance", int'(bus.distance), 511);
    cyc(5);

    // 6: reset in the middle of the trigger pulse
    bus.ENABLE = 1'b1;
    wait_sig("t6_rise", 0, 1'b1, 10, n);
    cyc(30);
    reset = 1'b1;
    cyc(1);
    check("t6_trigger",  int'(bus.trigger),  0);
    check("t6_busy",     int'(bus.busy),     0);
    check("t6_distance", int'(bus.distance), 0);
    check("t6_timeout",  int'(bus.timeout),  0);
    check("t6_done",     int'(bus.done),     0);
    reset = 1'b0;
    wait_sig("t6_rerise", 0, 1'b1, 10, n);
    check("t6_rerise_latency", n, 1);
    wait_sig("t6_refall", 0, 1'b0, 400, n);
    check("t6_trig_width", n, 100);
    cyc(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
